// File: rtl/vote_scan_ctrl.sv
// Vote accumulation and scan sequencer for the class-decision path.
// Counts per-class votes, runs one finder scan per frame, hands off result.
module vote_scan_ctrl #(
  parameter int NUM       = 18,
  parameter int MIN_VOTES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vote_valid,
  input  logic [4:0]       i_vote_idx,
  output logic             o_vote_ready,
  input  logic             i_frame_done,
  input  logic             i_abort,
  output logic [NUM*7-1:0] o_cnt,
  output logic             o_cnt_en,
  output logic             o_cnt_clr,
  input  logic [4:0]       i_max_idx,
  input  logic [6:0]       i_max,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [4:0]       o_res_idx,
  output logic [6:0]       o_res_max,
  output logic             o_res_none
);

  typedef enum logic [2:0] {
    S_ACCUM,
    S_SCAN,
    S_SETTLE,
    S_OUT,
    S_CLEAR
  } state_t;

  localparam logic [6:0] MINV = 7'(MIN_VOTES);
  localparam logic [4:0] LAST = 5'(NUM - 1);

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_scan;
  logic [6:0] r_cnt [NUM];
  logic       w_acc;
  logic       w_last;

  // abort suppresses the handshake so a same-cycle vote is held by the source
  assign o_vote_ready = (r_state == S_ACCUM) && !i_abort;
  assign w_acc        = i_vote_valid && o_vote_ready;
  assign w_last       = (r_scan == LAST);

  for (genvar k = 0; k < NUM; k++) begin : g_out
    assign o_cnt[k*7 +: 7] = r_cnt[k];
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_ACCUM:  if (i_frame_done) w_next = S_SCAN;
      S_SCAN:   if (w_last) w_next = S_SETTLE;
      S_SETTLE: w_next = S_OUT;
      S_OUT:    if (i_res_ready) w_next = S_CLEAR;
      S_CLEAR:  w_next = S_ACCUM;
      default:  w_next = S_ACCUM;
    endcase
    if (i_abort && r_state != S_CLEAR) w_next = S_CLEAR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ACCUM;
      r_scan      <= '0;
      o_cnt_en    <= 1'b0;
      o_cnt_clr   <= 1'b0;
      o_res_valid <= 1'b0;
      o_res_idx   <= '0;
      o_res_max   <= '0;
      o_res_none  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_scan      <= (r_state == S_SCAN) ? r_scan + 5'd1 : '0;
      o_cnt_en    <= (w_next == S_SCAN);
      o_cnt_clr   <= (w_next == S_CLEAR);
      o_res_valid <= (w_next == S_OUT);
      if (r_state == S_SETTLE && !i_abort) begin
        o_res_idx  <= i_max_idx;
        o_res_max  <= i_max;
        o_res_none <= (i_max < MINV);
      end
    end
  end

  // out-of-range indices complete the handshake but match no counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM; k++) r_cnt[k] <= '0;
    end else if (r_state == S_CLEAR) begin
      for (int k = 0; k < NUM; k++) r_cnt[k] <= '0;
    end else if (w_acc) begin
      for (int k = 0; k < NUM; k++) begin
        if (i_vote_idx == 5'(k) && r_cnt[k] != 7'h7f)
          r_cnt[k] <= r_cnt[k] + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_vote_scan_ctrl.sv
// Bench for vote_scan_ctrl: table of frames plus hold, abort
// and reset sequences, with a behavioural serial max-finder.
module tb_vote_scan_ctrl;

  localparam int NUM = 18;
  localparam int W   = NUM * 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_vote_valid = 1'b0;
  logic [4:0]   i_vote_idx = '0;
  logic         o_vote_ready;
  logic         i_frame_done = 1'b0;
  logic         i_abort = 1'b0;
  logic [W-1:0] o_cnt;
  logic         o_cnt_en;
  logic         o_cnt_clr;
  logic [4:0]   i_max_idx;
  logic [6:0]   i_max;
  logic         o_res_valid;
  logic         i_res_ready = 1'b0;
  logic [4:0]   o_res_idx;
  logic [6:0]   o_res_max;
  logic         o_res_none;

  always #5 clk = ~clk;

  vote_scan_ctrl #(.NUM(NUM), .MIN_VOTES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_vote_valid(i_vote_valid), .i_vote_idx(i_vote_idx),
    .o_vote_ready(o_vote_ready), .i_frame_done(i_frame_done),
    .i_abort(i_abort), .o_cnt(o_cnt), .o_cnt_en(o_cnt_en),
    .o_cnt_clr(o_cnt_clr), .i_max_idx(i_max_idx), .i_max(i_max),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_idx(o_res_idx), .o_res_max(o_res_max),
    .o_res_none(o_res_none)
  );

  // serial finder: strict compare keeps the lowest index on ties
  int         fj;
  logic [4:0] fidx;
  logic [6:0] fmax;
  assign i_max_idx = fidx;
  assign i_max     = fmax;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fj <= 0; fidx <= '0; fmax <= '0;
    end else if (o_cnt_clr) begin
      fj <= 0; fidx <= '0; fmax <= '0;
    end else if (o_cnt_en && fj < NUM) begin
      if (o_cnt[fj*7 +: 7] > fmax) begin
        fmax <= o_cnt[fj*7 +: 7];
        fidx <= 5'(fj);
      end
      fj <= fj + 1;
    end
  end

  typedef struct {
    int ca; int na; int cb; int nb;
    int eidx; int emax; int enone;
  } vec_t;

  vec_t tv[7];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_cnt(input vec_t v);
    logic [W-1:0] e;
    e = '0;
    if (v.ca < NUM) e[v.ca*7 +: 7] = 7'((v.na > 127) ? 127 : v.na);
    if (v.cb < NUM) e[v.cb*7 +: 7] = 7'((v.nb > 127) ? 127 : v.nb);
    return e;
  endfunction

  task automatic send_votes(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_vote_valid = 1'b1;
      i_vote_idx   = 5'(c);
    end
  endtask

  task automatic run_frame(input vec_t v, input int hold, input string tg);
    int en_n, fv, ovl, rdy_scan;
    logic [4:0] idx0;
    send_votes(v.ca, v.na);
    send_votes(v.cb, v.nb);
    @(negedge clk);
    i_vote_valid = 1'b0;
    chkw({tg, " cnt"}, o_cnt, exp_cnt(v));
    i_frame_done = 1'b1;
    @(negedge clk);
    i_frame_done = 1'b0;
    en_n = 0; fv = 0; ovl = 0; rdy_scan = 1;
    for (int k = 1; k <= 40 && fv == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (o_cnt_en) en_n++;
      if (o_cnt_en && o_cnt_clr) ovl = 1;
      if (k == 3) rdy_scan = int'(o_vote_ready);
      if (o_res_valid) fv = k;
    end
    chk({tg, " en_cycles"}, en_n, NUM);
    chk({tg, " valid_at"}, fv, NUM + 2);
    chk({tg, " en_clr_overlap"}, ovl, 0);
    chk({tg, " ready_in_scan"}, rdy_scan, 0);
    chk({tg, " res_idx"}, int'(o_res_idx), v.eidx);
    chk({tg, " res_max"}, int'(o_res_max), v.emax);
    chk({tg, " res_none"}, int'(o_res_none), v.enone);
    idx0 = o_res_idx;
    for (int h = 0; h < hold; h++) begin
      if (h == 2) begin
        i_frame_done = 1'b1;
        i_vote_valid = 1'b1;
        i_vote_idx   = 5'd6;
      end
      if (h == 3) i_frame_done = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) begin
      chk({tg, " hold_valid"}, int'(o_res_valid), 1);
      chk({tg, " hold_idx"}, int'(o_res_idx), int'(idx0));
      chk({tg, " hold_ready"}, int'(o_vote_ready), 0);
    end
    i_res_ready = 1'b1;
    @(negedge clk);
    i_res_ready = 1'b0;
    chk({tg, " clr_pulse"}, int'(o_cnt_clr), 1);
    chk({tg, " valid_drop"}, int'(o_res_valid), 0);
    @(negedge clk);
    chkw({tg, " cleared"}, o_cnt, '0);
    chk({tg, " ready_back"}, int'(o_vote_ready), 1);
    chk({tg, " clr_end"}, int'(o_cnt_clr), 0);
    if (hold > 0) begin
      @(negedge clk);
      i_vote_valid = 1'b0;
      chk({tg, " late_vote"}, int'(o_cnt[6*7 +: 7]), 1);
      chk({tg, " fd_ignored"}, int'(o_cnt_en), 0);
    end
  endtask

  initial begin
    int seen;
    tv[0] = '{5, 4, 9, 2, 5, 4, 0};
    tv[1] = '{3, 6, 7, 6, 3, 6, 0};
    tv[2] = '{0, 130, 20, 1, 0, 127, 0};
    tv[3] = '{2, 1, 0, 0, 2, 1, 1};
    tv[4] = '{0, 0, 0, 0, 0, 0, 1};
    tv[5] = '{17, 3, 1, 2, 17, 3, 0};
    tv[6] = '{4, 2, 30, 2, 4, 2, 1};

    repeat (2) @(negedge clk);
    chk("rst en", int'(o_cnt_en), 0);
    chk("rst clr", int'(o_cnt_clr), 0);
    chk("rst valid", int'(o_res_valid), 0);
    chkw("rst cnt", o_cnt, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst ready", int'(o_vote_ready), 1);

    for (int i = 0; i < 7; i++) run_frame(tv[i], 0, $sformatf("f%0d", i));
    run_frame(tv[0], 10, "hold");

    // abort at scan cycle 7; counter 6 still holds the late vote
    send_votes(5, 3);
    @(negedge clk);
    i_vote_valid = 1'b0;
    i_frame_done = 1'b1;
    @(negedge clk);
    i_frame_done = 1'b0;
    repeat (6) @(negedge clk);
    chk("ab en_before", int'(o_cnt_en), 1);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("ab en_drop", int'(o_cnt_en), 0);
    chk("ab clr", int'(o_cnt_clr), 1);
    chk("ab valid", int'(o_res_valid), 0);
    @(negedge clk);
    chkw("ab cleared", o_cnt, '0);
    chk("ab ready", int'(o_vote_ready), 1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_res_valid || o_cnt_en) seen = 1;
    end
    chk("ab no_result", seen, 0);

    // abort beats a same-cycle vote and frame_done
    i_abort = 1'b1;
    i_vote_valid = 1'b1;
    i_vote_idx = 5'd4;
    i_frame_done = 1'b1;
    #1;
    chk("ab2 ready", int'(o_vote_ready), 0);
    @(negedge clk);
    i_abort = 1'b0;
    i_vote_valid = 1'b0;
    i_frame_done = 1'b0;
    chk("ab2 clr", int'(o_cnt_clr), 1);
    chk("ab2 en", int'(o_cnt_en), 0);
    chkw("ab2 cnt", o_cnt, '0);

    // asynchronous reset in the middle of a scan
    @(negedge clk);
    send_votes(5, 2);
    @(negedge clk);
    i_vote_valid = 1'b0;
    i_frame_done = 1'b1;
    @(negedge clk);
    i_frame_done = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst en", int'(o_cnt_en), 0);
    chk("mrst clr", int'(o_cnt_clr), 0);
    chk("mrst valid", int'(o_res_valid), 0);
    chk("mrst idx", int'(o_res_idx), 0);
    chk("mrst max", int'(o_res_max), 0);
    chk("mrst none", int'(o_res_none), 0);
    chkw("mrst cnt", o_cnt, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_res_valid || o_cnt_en) seen = 1;
    end
    chk("mrst no_result", seen, 0);
    chk("mrst ready", int'(o_vote_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vote_scan_ctrl.md
# vote_scan_ctrl

Vote accumulation and scan sequencer for the class-decision path. Owns a bank of NUM 7-bit saturating vote counters, accepts per-class votes over a valid/ready handshake, and, on frame end, drives the serial max-finder through exactly one NUM-cycle scan. It then captures the winning index and count, presents them on a result handshake, and clears both its counters and the finder before accepting the next frame.

## Interface
- NUM, 18: number of classes / vote counters (2..31)
- MIN_VOTES, 3: minimum winning count for a valid decision (0..127)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_vote_valid  in  1  vote present
- i_vote_idx  in  5  class index of vote
- o_vote_ready  out  1  vote accepted this cycle (high only in ACCUM)
- i_frame_done  in  1  end-of-frame pulse; starts scan
- i_abort  in  1  discard frame, clear everything
- o_cnt  out  NUM*7  counter bank to finder, class k at bits [k*7 +: 7]
- o_cnt_en  out  1  finder scan enable
- o_cnt_clr  out  1  finder clear
- i_max_idx  in  5  finder winning index
- i_max  in  7  finder winning count
- o_res_valid  out  1  result available
- i_res_ready  in  1  result consumed
- o_res_idx  out  5  captured winning index
- o_res_max  out  7  captured winning count
- o_res_none  out  1  i_max < MIN_VOTES (no decision)

## Operation
- Reset: state ACCUM, all counters 0, o_cnt_en=0, o_cnt_clr=0, o_res_valid=0, o_res_idx=0, o_res_max=0, o_res_none=0; o_vote_ready=1 after reset release.
- ACCUM: o_vote_ready=1. Vote accepted when i_vote_valid && o_vote_ready. Counter[i_vote_idx] += 1, saturating at 127. i_vote_idx >= NUM: vote accepted (handshake completes), no counter change.
- ACCUM + i_frame_done -> SCAN. Vote accepted in the same cycle is counted before scan.
- SCAN: o_cnt_en=1 for exactly NUM consecutive cycles (internal 5-bit counter 0..NUM-1), o_vote_ready=0, counters frozen. After the NUM-th cycle -> SETTLE.
- SETTLE: one cycle, o_cnt_en=0. i_max_idx/i_max are registered into o_res_idx/o_res_max; o_res_none = (i_max < MIN_VOTES). -> OUT.
- OUT: o_res_valid=1, result stable until handshake. i_res_ready high -> CLEAR.
- CLEAR: o_cnt_clr=1 for one cycle, o_cnt_en=0; all counters cleared at the end of this cycle; o_res_valid=0. -> ACCUM.
- i_frame_done outside ACCUM: ignored. i_vote_valid outside ACCUM: not accepted, so the source holds it.
- i_abort (any state except CLEAR) -> CLEAR the next cycle: o_cnt_en drops immediately, no result is presented, and o_res_valid drops. Abort has priority over frame_done and vote in the same cycle; that vote is not accepted. i_abort in CLEAR: no effect.
- Ties: the finder keeps the lowest index, and the block passes that through unchanged.
- All-zero frame: idx 0, max 0, o_res_none=1 when MIN_VOTES >= 1.
- o_cnt_clr and o_cnt_en are never high in the same cycle.

## Timing
- All outputs registered except o_vote_ready (decoded from state).
- i_frame_done sampled at edge of cycle T -> o_cnt_en high cycles T+1..T+NUM -> SETTLE at T+NUM+1 -> o_res_valid high from T+NUM+2.
- Result handshake at cycle R -> o_cnt_clr high at R+1, o_res_valid low at R+1 -> counters read 0 and o_vote_ready=1 at R+2.
- Minimum frame-to-frame turnaround with i_res_ready held high: NUM+4 cycles.
- A vote accepted at cycle V appears on o_cnt at V+1.
- Asynchronous reset mid-scan or mid-result: everything returns to reset values immediately. No partial result is emitted after release.

## Test plan
- NUM=18, MIN_VOTES=3, votes to class 5 ×4 and class 9 ×2, then frame_done, i_res_ready=1 -> o_cnt_en high exactly 18 cycles; o_res_valid=1 with idx 5, max 4, none 0 at T+20; o_cnt_clr pulse; counters all 0.
- Votes to classes 3 and 7, ×6 each -> idx 3, max 6 (tie resolves to lowest index).
- 130 votes to class 0 -> counter saturates; result idx 0, max 127. A vote with idx 20 leaves all counters unchanged.
- Single vote to class 2 -> max 1, o_res_none=1. Empty frame -> idx 0, max 0, none 1.
- Hold i_res_ready=0 for 10 cycles -> result stable and o_vote_ready=0. A vote and a frame_done arriving during OUT are ignored, and the vote is accepted after the clear.
- Assert i_abort at scan cycle 7 -> o_cnt_en drops, no o_res_valid, o_cnt_clr pulses, counters 0. Repeat with rst_n asserted mid-scan -> all outputs at reset values.
